// File: rtl/input_cond_pkg.sv
// input_cond_pkg: shared constants for the input conditioner and its channel indices.
package input_cond_pkg;
    localparam int INPUT_COND_DB_DEFAULT = 16;
    localparam int INPUT_COND_CH         = 3;
    localparam int IC_A                  = 0;
    localparam int IC_B                  = 1;
    localparam int IC_C                  = 2;
endpackage

// File: rtl/input_cond_ch.sv
// input_cond_ch: one channel of two-flop sync, debounce counter, accepted level and edge pulses.
module input_cond_ch
    import input_cond_pkg::*;
#(
    parameter int  DB_CYCLES = INPUT_COND_DB_DEFAULT,
    localparam int CNT_W     = $clog2(DB_CYCLES)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);
    if (DB_CYCLES < 2) begin : g_bad_db
        $error("input_cond_ch: DB_CYCLES must be >= 2");
    end
    logic             r_s1;
    logic             r_s2;
    logic             r_lvl;
    logic [CNT_W-1:0] r_cnt;
    logic             w_diff;
    logic             w_done;
    logic             w_lvl_next;
    logic [CNT_W-1:0] w_cnt_next;
    // Counter only runs while s2 disagrees with the level, and clears on acceptance, so it never wraps.
    always_comb begin
        w_diff     = r_s2 ^ r_lvl;
        w_done     = w_diff && (r_cnt == CNT_MAX);
        w_lvl_next = w_done ? r_s2 : r_lvl;
        w_cnt_next = (!w_diff || w_done) ? '0 : r_cnt + 1'b1;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_cnt  <= '0;
            r_lvl  <= 1'b0;
            o_rise <= 1'b0;
            o_fall <= 1'b0;
        end else begin
            r_s1   <= i_raw;
            r_s2   <= r_s1;
            r_cnt  <= w_cnt_next;
            r_lvl  <= w_lvl_next;
            o_rise <= ~r_lvl & w_lvl_next;
            o_fall <= r_lvl & ~w_lvl_next;
        end
    end
    assign o_level = r_lvl;
endmodule

// File: rtl/input_cond.sv
// input_cond: per-channel synchroniser and debouncer feeding clean levels and edge pulses to test.
module input_cond
    import input_cond_pkg::*;
#(
    parameter int  CH        = INPUT_COND_CH,
    parameter int  DB_CYCLES = INPUT_COND_DB_DEFAULT,
    localparam int CNT_W     = $clog2(DB_CYCLES)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [CH-1:0] raw_i,
    output logic [CH-1:0] level_o,
    output logic [CH-1:0] rise_o,
    output logic [CH-1:0] fall_o
);
    if (DB_CYCLES < 2 || CNT_W < 1) begin : g_bad_db
        $error("input_cond: DB_CYCLES must be >= 2");
    end
    for (genvar i = 0; i < CH; i++) begin : g_ch
        input_cond_ch #(.DB_CYCLES(DB_CYCLES)) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_raw  (raw_i[i]),
            .o_level(level_o[i]),
            .o_rise (rise_o[i]),
            .o_fall (fall_o[i])
        );
    end
endmodule

// File: doc/input_cond.md
# input_cond

Three-channel input conditioner placed directly upstream of the `test` block. It synchronises asynchronous raw inputs into the `clk` domain, debounces each channel, and drives clean levels onto `test`'s `a_i`, `b_i` and `c_i`. It also emits single-cycle rise and fall pulses per channel for event logic.

## Interface
- `CH`, 3, number of channels. Bit 0 maps to `a_i`, bit 1 to `b_i`, bit 2 to `c_i`.
- `DB_CYCLES`, 16, number of consecutive synchronised cycles a new value must hold before it is accepted. Must be ≥ 2; elaboration fails otherwise.
- `CNT_W`, `$clog2(DB_CYCLES)`, debounce counter width. Derived; do not override.

Ports:
- `clk`  in  1  single clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `raw_i`  in  CH  asynchronous raw inputs.
- `level_o`  out  CH  debounced level.
- `rise_o`  out  CH  one-cycle pulse on a 0→1 change of `level_o`.
- `fall_o`  out  CH  one-cycle pulse on a 1→0 change of `level_o`.

## Operation
Each channel is fully independent. Per channel:
- **Sync:** two flops, `s1 <= raw`, `s2 <= s1`.
- **Debounce:** a counter `cnt` and the accepted level `lvl`, which drives `level_o`. On each edge:
  - If `s2 == lvl`: `cnt <= 0`.
  - Else if `cnt == DB_CYCLES-1`: `lvl <= s2`, `cnt <= 0`.
  - Else: `cnt <= cnt + 1`.
- **Glitch rejection:** any run of a differing `s2` value shorter than `DB_CYCLES` cycles clears the counter and leaves `lvl` unchanged.
- **Counter range:** `cnt` never exceeds `DB_CYCLES-1`, so it cannot wrap.
- **Pulses:** `rise_o` and `fall_o` are registered and update on the same edge as `lvl`.
  - `rise_o <= ~lvl & lvl_next`.
  - `fall_o <= lvl & ~lvl_next`.
  - They are never both high, and they last exactly one cycle.
- **Reset:** every flop (`s1`, `s2`, `cnt`, `lvl`, `rise_o`, `fall_o`) is asynchronously cleared to 0.
  - Result: a raw input held high through reset produces a normal `rise_o` once its debounce completes after release.

## Timing
- **Reset values:** `level_o = 0`, `rise_o = 0`, `fall_o = 0`.
- **Latency:** take edge 0 as the first edge at which `s1` captures a changed, stable `raw_i`.
  - `s2` changes at edge 1.
  - `cnt` counts at edges 2 … `DB_CYCLES`.
  - `lvl` updates at edge `DB_CYCLES+1`.
  - `level_o` and the matching pulse are therefore visible after edge `DB_CYCLES+1` (edge 5 for `DB_CYCLES=4`).
- **Minimum accepted pulse:** a raw pulse of exactly `DB_CYCLES` cycles, aligned to sampling, is accepted. One of `DB_CYCLES-1` cycles is rejected.
- **Change after acceptance:** `s2` returning to the old value on the edge after `lvl` updates starts a fresh count. The minimum spacing between consecutive pulses on one channel is `DB_CYCLES` cycles.
- **Reset mid-count:**
  - Assertion clears the partial count and level immediately.
  - After deassertion, the first `s1` capture is at the first `clk` edge. No pulse is emitted until a full debounce completes.
- **Deassertion:** `rst_n` deassertion is assumed synchronous to `clk` at system level. This block does not resynchronise it.

## Structure
- **Package `input_cond_pkg`:**
  - `INPUT_COND_DB_DEFAULT = 16`.
  - `INPUT_COND_CH = 3`.
  - Named channel indices `IC_A = 0`, `IC_B = 1`, `IC_C = 2`, used by the top-level wiring into `test`.
- **Sub-module `input_cond_ch`:** one channel (sync, debounce counter, level, pulse flops), parameterised by `DB_CYCLES`.
- **Top `input_cond`:** a generate loop of `CH` instances, with no other logic.

## Test plan
All scenarios use `DB_CYCLES=4` and `CH=3`, with a 100 ns clock.
1. Hold `raw_i=3'b111` through reset, then release → `level_o=000` during reset; `level_o=111` and `rise_o=111` appear 5 edges after the first post-reset edge; `rise_o=000` on the next cycle.
2. Drive `raw_i[0]` high for 3 cycles, then low → `level_o[0]` stays 0; `rise_o[0]` never pulses.
3. Drive `raw_i[0]` high for exactly 4 cycles, then low → `rise_o[0]` pulses once; 4 cycles later `fall_o[0]` pulses once; `level_o[0]` ends at 0.
4. With `level_o[1]=1`, toggle `raw_i[1]` low/high every cycle for 20 cycles, then hold low → no pulses during toggling; `fall_o[1]` pulses exactly once, 5 edges after the hold begins.
5. Set `raw_i[2]` high at edge 0 and `raw_i[0]` high at edge 2 → `rise_o[2]` at edge 5 and `rise_o[0]` at edge 7, with no cross-channel interaction.
6. Start a debounce on `raw_i[1]`, assert `rst_n=0` after 2 counting cycles, release, and keep `raw_i[1]` high → outputs clear immediately; `rise_o[1]` occurs 5 edges after release, never earlier.
